pe_tile_sequencer: RTL and testbench
====================================

# pe_tile_sequencer

Sequences one output-stationary matrix tile through the PE array interface. On `start_i` it streams `k_len_i` operand beats from the A and B operand buffers into the PE array interface and clears the accumulators on beat 0. It then waits a fixed drain time and writes the `PE_ROWS × PE_COLS` partial-sum tile out one row per handshake. It sits between the control unit (which issues tile jobs) and the PE array interface and its operand and result buffers.

## Interface
- `DATA_WIDTH`, `nmcu_pkg::DATA_WIDTH`, operand width
- `PSUM_WIDTH`, `nmcu_pkg::PSUM_WIDTH`, partial-sum width
- `PE_ROWS`, `nmcu_pkg::PE_ROWS`, array rows
- `PE_COLS`, `nmcu_pkg::PE_COLS`, array columns
- `ADDR_W`, 10, operand buffer address width
- `K_W`, `nmcu_pkg::SEQ_K_WIDTH` (12), width of reduction length
- `DRAIN_CYCLES`, `(PE_ROWS+PE_COLS-2)+5`, cycles from last valid beat until `pe_result_i` is final
- `clk`  in  1  clock
- `rst_n`  in  1  reset: asynchronous, active-low
- `start_i`  in  1  job request, sampled only in IDLE
- `k_len_i`  in  K_W  reduction length in beats
- `a_base_i`, `b_base_i`  in  ADDR_W  buffer base addresses
- `busy_o`  out  1  high whenever state ≠ IDLE
- `done_o`  out  1  one-cycle job-complete pulse
- `a_rd_en_o`, `b_rd_en_o`  out  1  buffer read strobes
- `a_rd_addr_o`, `b_rd_addr_o`  out  ADDR_W  read addresses
- `a_rd_data_i`  in  [PE_ROWS][DATA_WIDTH]  A read data, valid 1 cycle after strobe
- `b_rd_data_i`  in  [PE_COLS][DATA_WIDTH]  B read data, valid 1 cycle after strobe
- `pe_cmd_valid_o`  out  1  beat valid to PE interface
- `pe_cmd_ready_i`  in  1  PE interface ready
- `pe_accum_en_o`  out  PE_ROWS  accumulate enable per row
- `pe_operand_a_o`  out  [PE_ROWS][DATA_WIDTH]  operand A beat
- `pe_operand_b_o`  out  [PE_COLS][DATA_WIDTH]  operand B beat
- `pe_result_i`  in  [PE_ROWS][PE_COLS][PSUM_WIDTH]  array results
- `res_valid_o`  out  1  result row valid
- `res_ready_i`  in  1  result sink ready
- `res_row_o`  out  $clog2(PE_ROWS)  row index of `res_data_o`
- `res_data_o`  out  [PE_COLS][PSUM_WIDTH]  result row

## Operation
- States: IDLE, STREAM, DRAIN, WRITEBACK, DONE.
- IDLE → STREAM
  - Taken when `start_i` is high, `k_len_i` ≠ 0 and `pe_cmd_ready_i` is high.
  - `k_len_i`, `a_base_i` and `b_base_i` are latched on this transition.
- IDLE → DONE: taken when `start_i` is high and `k_len_i` = 0. No reads and no writes occur.
- STREAM
  - Issues beat i = 0..K-1: both read strobes high, addresses base+i.
  - Addresses wrap modulo 2^ADDR_W.
  - Exits to DRAIN after beat K-1 is issued.
- Beat output
  - `pe_cmd_valid_o` is a 1-cycle-delayed copy of the read strobe.
  - Operand outputs pass read data straight through.
  - `pe_accum_en_o` is all-0 for beat 0 and all-1 for beats 1..K-1.
- DRAIN
  - Counts DRAIN_CYCLES, starting the cycle after the last valid beat.
  - `pe_cmd_valid_o` stays low; the interface flushes zeros with accumulate on, so results stay stable.
  - Then goes to WRITEBACK.
- WRITEBACK
  - Presents row r = 0..PE_ROWS-1: `res_data_o = pe_result_i[r]`, `res_valid_o` high.
  - r advances only on `res_valid_o & res_ready_i`.
  - After row PE_ROWS-1 is accepted, goes to DONE.
- DONE: `done_o` high for exactly 1 cycle, then IDLE.
- `start_i` outside IDLE is ignored.
- `pe_cmd_ready_i` low during STREAM is a protocol violation and is flagged by a bench assertion. It causes no stall.

## Timing
- Reset: state IDLE, all counters 0. All outputs 0: `busy_o`, `done_o`, strobes, addresses, `pe_cmd_valid_o`, `pe_accum_en_o`, operands, `res_valid_o`, `res_row_o`, `res_data_o`.
- Reset mid-job aborts immediately. No partial `done_o` is produced.
- Cycle numbering: `start_i` is sampled at edge 0.
  - Read strobes are high in cycles 1..K.
  - `pe_cmd_valid_o` is high in cycles 2..K+1.
  - DRAIN occupies cycles K+2..K+1+DRAIN_CYCLES.
- With `res_ready_i` held high:
  - Rows go out in cycles K+2+DRAIN_CYCLES .. K+1+DRAIN_CYCLES+PE_ROWS.
  - `done_o` is high in cycle K+2+DRAIN_CYCLES+PE_ROWS.
- `busy_o` is high from cycle 1 through the `done_o` cycle inclusive.
- `res_data_o` and `res_row_o` hold stable while `res_valid_o & !res_ready_i`.
- Back-to-back jobs: the earliest accepted `start_i` is the cycle after `done_o`.

## Structure
- `nmcu_pkg` holds:
  - `SEQ_K_WIDTH`.
  - `typedef enum logic [2:0] seq_state_e {SEQ_IDLE, SEQ_STREAM, SEQ_DRAIN, SEQ_WB, SEQ_DONE}`.
- Single module; no sub-module is natural. Beat, drain and row counters and the row mux are inline.

## Test plan
All scenarios use PE_ROWS=PE_COLS=4, DATA_WIDTH=8, and a behavioural buffer and PE model.
- K=1, A=all 2, B=all 3, `res_ready_i`=1 → every psum = 6. 4 row beats with rows 0..3 in order. `done_o` at cycle 3+DRAIN_CYCLES+4.
- K=8, A=i+1, B=1 → every psum = 36. `pe_accum_en_o` is 0 only on beat 0.
- K=0 → `done_o` at cycle 1. No read strobes and no `res_valid_o`.
- `res_ready_i` toggled 1,0,0,1,… during WRITEBACK → `res_row_o`/`res_data_o` hold while stalled. Exactly 4 accepts, then `done_o`.
- a_base=1022, K=4 → A addresses 1022, 1023, 0, 1.
- `rst_n` asserted mid-STREAM → all outputs 0 immediately. A subsequent K=2 job completes correctly. `start_i` pulsed while busy → ignored.

Source files
------------

// File: rtl/nmcu_pkg.sv
// Shared constants and types for the near-memory compute unit.
package nmcu_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int PSUM_WIDTH  = 32;
    localparam int PE_ROWS     = 4;
    localparam int PE_COLS     = 4;
    localparam int SEQ_K_WIDTH = 12;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_STREAM,
        SEQ_DRAIN,
        SEQ_WB,
        SEQ_DONE
    } seq_state_e;

endpackage

// File: rtl/pe_tile_sequencer.sv
// Sequences one output-stationary tile: streams K operand beats into the
// PE array, waits for the array pipeline to drain, then writes the partial
// sum tile out one row per handshake.
module pe_tile_sequencer #(
    parameter int DATA_WIDTH   = nmcu_pkg::DATA_WIDTH,
    parameter int PSUM_WIDTH   = nmcu_pkg::PSUM_WIDTH,
    parameter int PE_ROWS      = nmcu_pkg::PE_ROWS,
    parameter int PE_COLS      = nmcu_pkg::PE_COLS,
    parameter int ADDR_W       = 10,
    parameter int K_W          = nmcu_pkg::SEQ_K_WIDTH,
    parameter int DRAIN_CYCLES = (PE_ROWS + PE_COLS - 2) + 5
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start_i,
    input  logic [K_W-1:0]                               k_len_i,
    input  logic [ADDR_W-1:0]                            a_base_i,
    input  logic [ADDR_W-1:0]                            b_base_i,
    output logic                                         busy_o,
    output logic                                         done_o,
    output logic                                         a_rd_en_o,
    output logic                                         b_rd_en_o,
    output logic [ADDR_W-1:0]                            a_rd_addr_o,
    output logic [ADDR_W-1:0]                            b_rd_addr_o,
    input  logic [PE_ROWS-1:0][DATA_WIDTH-1:0]           a_rd_data_i,
    input  logic [PE_COLS-1:0][DATA_WIDTH-1:0]           b_rd_data_i,
    output logic                                         pe_cmd_valid_o,
    input  logic                                         pe_cmd_ready_i,
    output logic [PE_ROWS-1:0]                           pe_accum_en_o,
    output logic [PE_ROWS-1:0][DATA_WIDTH-1:0]           pe_operand_a_o,
    output logic [PE_COLS-1:0][DATA_WIDTH-1:0]           pe_operand_b_o,
    input  logic [PE_ROWS-1:0][PE_COLS-1:0][PSUM_WIDTH-1:0] pe_result_i,
    output logic                                         res_valid_o,
    input  logic                                         res_ready_i,
    output logic [$clog2(PE_ROWS)-1:0]                   res_row_o,
    output logic [PE_COLS-1:0][PSUM_WIDTH-1:0]           res_data_o
);

    import nmcu_pkg::*;

    localparam int ROW_W   = $clog2(PE_ROWS);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    seq_state_e state_q, state_d;

    logic [K_W-1:0]     k_q;
    logic [K_W-1:0]     beat_q, beat_d;
    logic [ADDR_W-1:0]  a_base_q, b_base_q;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               valid_q;
    logic               accum_q;
    logic               launch;
    logic               rd_en;
    logic               last_beat;
    logic               drain_done;
    logic               last_row;
    logic               res_fire;

    assign rd_en      = (state_q == SEQ_STREAM);
    assign last_beat  = (beat_q == (k_q - K_W'(1)));
    assign drain_done = (drain_q == DRAIN_W'(DRAIN_CYCLES));
    assign last_row   = (row_q == ROW_W'(PE_ROWS - 1));
    assign res_valid_o = (state_q == SEQ_WB);
    assign res_fire   = res_valid_o & res_ready_i;

    // Next-state and counter update; the drain counter starts at 0 in the
    // cycle that still carries the last valid beat, so reaching DRAIN_CYCLES
    // means that many full cycles have passed since that beat.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        drain_d = drain_q;
        row_d   = row_q;
        launch  = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (start_i) begin
                    if (k_len_i == '0) begin
                        state_d = SEQ_DONE;
                    end else if (pe_cmd_ready_i) begin
                        state_d = SEQ_STREAM;
                        launch  = 1'b1;
                        beat_d  = '0;
                    end
                end
            end
            SEQ_STREAM: begin
                if (last_beat) begin
                    state_d = SEQ_DRAIN;
                    beat_d  = '0;
                    drain_d = '0;
                end else begin
                    beat_d = beat_q + K_W'(1);
                end
            end
            SEQ_DRAIN: begin
                if (drain_done) begin
                    state_d = SEQ_WB;
                    drain_d = '0;
                    row_d   = '0;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            SEQ_WB: begin
                if (res_fire) begin
                    if (last_row) begin
                        state_d = SEQ_DONE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            SEQ_DONE: begin
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    // State and counter registers; reset aborts any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEQ_IDLE;
            beat_q  <= '0;
            drain_q <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
            row_q   <= row_d;
        end
    end

    // Job parameters are captured once at launch so the requester may change them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q      <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
        end else if (launch) begin
            k_q      <= k_len_i;
            a_base_q <= a_base_i;
            b_base_q <= b_base_i;
        end
    end

    // Beat qualifiers trail the read strobe by one cycle to line up with read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            accum_q <= 1'b0;
        end else begin
            valid_q <= rd_en;
            accum_q <= rd_en && (beat_q != '0);
        end
    end

    assign busy_o      = (state_q != SEQ_IDLE);
    assign done_o      = (state_q == SEQ_DONE);
    assign a_rd_en_o   = rd_en;
    assign b_rd_en_o   = rd_en;
    assign a_rd_addr_o = rd_en ? (a_base_q + ADDR_W'(beat_q)) : '0;
    assign b_rd_addr_o = rd_en ? (b_base_q + ADDR_W'(beat_q)) : '0;

    assign pe_cmd_valid_o = valid_q;
    assign pe_accum_en_o  = {PE_ROWS{accum_q}};
    assign pe_operand_a_o = valid_q ? a_rd_data_i : '0;
    assign pe_operand_b_o = valid_q ? b_rd_data_i : '0;

    assign res_row_o  = row_q;
    assign res_data_o = res_valid_o ? pe_result_i[row_q] : '0;

endmodule

// File: tb/tb_pe_tile_sequencer.sv
// Directed bench for pe_tile_sequencer with behavioural operand buffers,
// a behavioural PE array and a result-row scoreboard.
module tb_pe_tile_sequencer;

    localparam int DW = 8;
    localparam int PW = 32;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int AW = 10;
    localparam int KW = 12;
    localparam int D  = (R + C - 2) + 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                          start_i;
    logic [KW-1:0]                 k_len_i;
    logic [AW-1:0]                 a_base_i, b_base_i;
    logic                          busy_o, done_o;
    logic                          a_rd_en_o, b_rd_en_o;
    logic [AW-1:0]                 a_rd_addr_o, b_rd_addr_o;
    logic [R-1:0][DW-1:0]          a_rd_data_i = '0;
    logic [C-1:0][DW-1:0]          b_rd_data_i = '0;
    logic                          pe_cmd_valid_o;
    logic                          pe_cmd_ready_i;
    logic [R-1:0]                  pe_accum_en_o;
    logic [R-1:0][DW-1:0]          pe_operand_a_o;
    logic [C-1:0][DW-1:0]          pe_operand_b_o;
    logic [R-1:0][C-1:0][PW-1:0]   pe_result_i = '0;
    logic                          res_valid_o;
    logic                          res_ready_i;
    logic [$clog2(R)-1:0]          res_row_o;
    logic [C-1:0][PW-1:0]          res_data_o;

    pe_tile_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .k_len_i        (k_len_i),
        .a_base_i       (a_base_i),
        .b_base_i       (b_base_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .a_rd_en_o      (a_rd_en_o),
        .b_rd_en_o      (b_rd_en_o),
        .a_rd_addr_o    (a_rd_addr_o),
        .b_rd_addr_o    (b_rd_addr_o),
        .a_rd_data_i    (a_rd_data_i),
        .b_rd_data_i    (b_rd_data_i),
        .pe_cmd_valid_o (pe_cmd_valid_o),
        .pe_cmd_ready_i (pe_cmd_ready_i),
        .pe_accum_en_o  (pe_accum_en_o),
        .pe_operand_a_o (pe_operand_a_o),
        .pe_operand_b_o (pe_operand_b_o),
        .pe_result_i    (pe_result_i),
        .res_valid_o    (res_valid_o),
        .res_ready_i    (res_ready_i),
        .res_row_o      (res_row_o),
        .res_data_o     (res_data_o)
    );

    logic [R-1:0][DW-1:0] a_mem [0:1023];
    logic [C-1:0][DW-1:0] b_mem [0:1023];
    logic [C-1:0][PW-1:0] sb [$];

    int vec_cnt = 0;
    int err_cnt = 0;
    int edge_cnt = 0;
    int e0 = 0;
    int cur_abase, cur_bbase;
    int rd_cnt, rd_first, val_cnt, val_first;
    int res_acc_cnt, res_first, res_last, exp_row;
    int done_cnt, done_cyc;
    bit toggle_mode = 1'b0;
    int tog_idx = 0;
    logic [3:0] tog_pat = 4'b1001;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Operand buffers: one cycle read latency
    always @(posedge clk) begin
        if (a_rd_en_o) a_rd_data_i <= a_mem[a_rd_addr_o];
        if (b_rd_en_o) b_rd_data_i <= b_mem[b_rd_addr_o];
    end

    // PE array: each valid beat either restarts or accumulates the outer product
    always @(posedge clk) begin
        if (pe_cmd_valid_o) begin
            for (int r = 0; r < R; r++) begin
                for (int c = 0; c < C; c++) begin
                    logic [PW-1:0] prod;
                    prod = PW'(pe_operand_a_o[r]) * PW'(pe_operand_b_o[c]);
                    pe_result_i[r][c] <= pe_accum_en_o[r] ? pe_result_i[r][c] + prod : prod;
                end
            end
        end
    end

    always @(posedge clk) edge_cnt++;

    // Output monitor sampled mid-cycle
    always @(negedge clk) begin
        int cyc;
        cyc = edge_cnt - e0 + 1;
        if (rst_n) begin
            if (a_rd_en_o) begin
                checkOutput("cmd_ready_in_stream", pe_cmd_ready_i, 1);
                checkOutput("b_rd_en", b_rd_en_o, 1);
                checkOutput("busy_in_stream", busy_o, 1);
                checkOutput("a_addr", a_rd_addr_o, (cur_abase + rd_cnt) % 1024);
                checkOutput("b_addr", b_rd_addr_o, (cur_bbase + rd_cnt) % 1024);
                if (rd_cnt == 0) rd_first = cyc;
                rd_cnt++;
            end
            if (pe_cmd_valid_o) begin
                if (val_cnt == 0) val_first = cyc;
                checkOutput("accum_en", pe_accum_en_o, (val_cnt == 0) ? 4'h0 : 4'hF);
                val_cnt++;
            end
            if (res_valid_o) begin
                if (sb.size() == 0) begin
                    checkOutput("res_unexpected", res_valid_o, 0);
                end else begin
                    checkOutput("res_row", res_row_o, exp_row);
                    checkOutput("res_data", res_data_o, sb[0]);
                    if (res_ready_i) begin
                        if (res_acc_cnt == 0) res_first = cyc;
                        res_last = cyc;
                        void'(sb.pop_front());
                        exp_row++;
                        res_acc_cnt++;
                    end
                end
            end
            if (done_o) begin
                checkOutput("busy_at_done", busy_o, 1);
                done_cyc = cyc;
                done_cnt++;
            end
        end
    end

    task automatic applyStimulus(input int k, input int ab, input int bb);
        logic [C-1:0][PW-1:0] row;
        for (int r = 0; r < R && k > 0; r++) begin
            row = '0;
            for (int c = 0; c < C; c++) begin
                int sum;
                sum = 0;
                for (int i = 0; i < k; i++)
                    sum += int'(a_mem[(ab + i) % 1024][r]) * int'(b_mem[(bb + i) % 1024][c]);
                row[c] = PW'(sum);
            end
            sb.push_back(row);
        end
        cur_abase = ab; cur_bbase = bb;
        rd_cnt = 0; rd_first = 0; val_cnt = 0; val_first = 0;
        res_acc_cnt = 0; res_first = 0; res_last = 0; exp_row = 0;
        done_cnt = 0; done_cyc = 0;
        @(posedge clk); #1;
        start_i = 1'b1; k_len_i = KW'(k); a_base_i = AW'(ab); b_base_i = AW'(bb);
        e0 = edge_cnt + 1;
        @(posedge clk); #1;
        start_i = 1'b0; k_len_i = 12'd7; a_base_i = '0; b_base_i = '0;
    endtask

    task automatic waitDone(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (toggle_mode) begin
                res_ready_i = tog_pat[tog_idx % 4];
                tog_idx++;
            end
            if (done_cnt != 0) break;
        end
        checkOutput("done_seen", done_cnt != 0, 1);
        checkOutput("busy_after_done", busy_o, 0);
    endtask

    task automatic checkJob(input int k, input int exp_done, input bit ready_high);
        checkOutput("done_count", done_cnt, 1);
        checkOutput("rd_count", rd_cnt, k);
        checkOutput("valid_count", val_cnt, k);
        checkOutput("row_accepts", res_acc_cnt, (k > 0) ? R : 0);
        checkOutput("sb_empty", sb.size(), 0);
        if (k > 0) begin
            checkOutput("rd_first", rd_first, 1);
            checkOutput("valid_first", val_first, 2);
            checkOutput("done_after_last_row", done_cyc, res_last + 1);
        end
        if (ready_high) begin
            checkOutput("done_cycle", done_cyc, exp_done);
            if (k > 0) checkOutput("res_first", res_first, k + 2 + D);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_ctrl"}, {busy_o, done_o, a_rd_en_o, b_rd_en_o, a_rd_addr_o, b_rd_addr_o,
                                     pe_cmd_valid_o, pe_accum_en_o, res_valid_o, res_row_o}, 0);
        checkOutput({tag, "_operands"}, {pe_operand_a_o, pe_operand_b_o}, 0);
        checkOutput({tag, "_data"}, res_data_o, 0);
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; k_len_i = '0; a_base_i = '0; b_base_i = '0;
        pe_cmd_ready_i = 1'b1; res_ready_i = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            a_mem[i] = '0;
            b_mem[i] = '0;
        end
        #1;
        checkReset("reset_init");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] K=1, A=2, B=3");
        a_mem[0] = {R{8'd2}};
        b_mem[0] = {C{8'd3}};
        applyStimulus(1, 0, 0);
        waitDone(100);
        checkJob(1, 1 + 2 + D + R, 1);

        $display("[TB] K=8, A=i+1, B=1");
        for (int i = 0; i < 8; i++) begin
            a_mem[16 + i] = {R{8'(i + 1)}};
            b_mem[40 + i] = {C{8'd1}};
        end
        applyStimulus(8, 16, 40);
        waitDone(100);
        checkJob(8, 8 + 2 + D + R, 1);

        $display("[TB] K=0");
        applyStimulus(0, 5, 5);
        waitDone(20);
        checkJob(0, 1, 1);

        $display("[TB] result backpressure");
        for (int i = 0; i < 3; i++) begin
            a_mem[200 + i] = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
            b_mem[210 + i] = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        end
        toggle_mode = 1'b1; tog_idx = 0;
        applyStimulus(3, 200, 210);
        waitDone(200);
        toggle_mode = 1'b0; res_ready_i = 1'b1;
        checkJob(3, 0, 0);

        $display("[TB] address wrap");
        for (int i = 0; i < 4; i++) begin
            a_mem[(1022 + i) % 1024] = {8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                                        8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))};
            b_mem[500 + i] = {8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                              8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))};
        end
        applyStimulus(4, 1022, 500);
        waitDone(100);
        checkJob(4, 4 + 2 + D + R, 1);

        $display("[TB] reset mid-stream");
        applyStimulus(8, 16, 40);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 checkReset("reset_mid");
        repeat (2) @(posedge clk);
        #1 checkOutput("done_during_reset", done_cnt, 0);
        checkReset("reset_hold");
        sb.delete();
        rst_n = 1'b1;

        $display("[TB] K=2 after reset, start while busy");
        for (int i = 0; i < 2; i++) begin
            a_mem[300 + i] = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
            b_mem[310 + i] = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        end
        applyStimulus(2, 300, 310);
        repeat (4) @(posedge clk);
        #1 start_i = 1'b1; k_len_i = 12'd5;
        @(posedge clk);
        #1 start_i = 1'b0;
        waitDone(100);
        checkJob(2, 2 + 2 + D + R, 1);
        repeat (3) @(posedge clk);
        #1 checkOutput("idle_after_ignored_start", busy_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
